// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one decoded instruction, tracks per-register
// pending-write busy bits, issues when hazards clear, and drains on halt.
module issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int NUM_FU   = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [1:0][3:0]      dec_readregs,
  input  logic [1:0]           dec_read_ena,
  input  logic [3:0]           dec_writereg,
  input  logic                 dec_write_ena,
  input  logic [7:0]           dec_flags,
  input  logic [3:0]           dec_fuid,
  input  logic                 dec_halt,
  input  logic [NUM_FU-1:0]    fu_ready,
  output logic                 iss_valid,
  output logic [3:0]           iss_fuid,
  output logic [1:0][3:0]      iss_readregs,
  output logic [1:0]           iss_read_ena,
  output logic [3:0]           iss_writereg,
  output logic                 iss_write_ena,
  output logic [7:0]           iss_flags,
  input  logic                 wb_valid,
  input  logic [3:0]           wb_reg,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 halted,
  output logic                 illegal_fu
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [4:0] FU_LIMIT = 5'(NUM_FU);

  state_t state_q, state_d;

  logic            hold_v;
  logic [1:0][3:0] hold_rr;
  logic [1:0]      hold_re;
  logic [3:0]      hold_wr;
  logic            hold_we;
  logic [7:0]      hold_flags;
  logic [3:0]      hold_fuid;
  logic            hold_halt;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff_busy;
  logic [15:0]         fu_ready_ext;

  logic fu_legal, src_ok, dst_ok, can_issue, drop, load, halt_done;

  // Zero-extend so any 4-bit fuid indexes safely; legality is checked separately.
  assign fu_ready_ext = 16'(fu_ready);

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_reg] = 1'b1;
  end

  // A writeback frees its register for hazard checks in the cycle it arrives.
  assign eff_busy = busy_q & ~wb_mask;

  assign fu_legal  = {1'b0, hold_fuid} < FU_LIMIT;
  assign src_ok    = (!hold_re[0] || !eff_busy[hold_rr[0]]) &&
                     (!hold_re[1] || !eff_busy[hold_rr[1]]);
  assign dst_ok    = !hold_we || !eff_busy[hold_wr];
  assign can_issue = hold_v && (state_q == RUN) && !hold_halt && fu_legal &&
                     fu_ready_ext[hold_fuid] && src_ok && dst_ok;
  assign drop      = hold_v && !fu_legal && (state_q == RUN) && !hold_halt;
  assign dec_ready = (state_q == RUN) && (!hold_v || can_issue || drop);
  assign load      = dec_valid && dec_ready;
  assign halt_done = (state_q == DRAIN) && (eff_busy == '0);

  always_comb begin
    set_mask = '0;
    if (can_issue && hold_we) set_mask[hold_wr] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hold_v && hold_halt) state_d = DRAIN;
      DRAIN:   if (eff_busy == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      busy_q     <= '0;
      illegal_fu <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= eff_busy | set_mask;
      illegal_fu <= drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v     <= 1'b0;
      hold_rr    <= '0;
      hold_re    <= '0;
      hold_wr    <= '0;
      hold_we    <= 1'b0;
      hold_flags <= '0;
      hold_fuid  <= '0;
      hold_halt  <= 1'b0;
    end else if (load) begin
      hold_v     <= 1'b1;
      hold_rr    <= dec_readregs;
      hold_re    <= dec_read_ena;
      hold_wr    <= dec_writereg;
      hold_we    <= dec_write_ena;
      hold_flags <= dec_flags;
      hold_fuid  <= dec_fuid;
      hold_halt  <= dec_halt;
    end else if (can_issue || drop || halt_done) begin
      hold_v <= 1'b0;
    end
  end

  assign iss_valid     = can_issue;
  assign iss_fuid      = hold_v ? hold_fuid  : '0;
  assign iss_readregs  = hold_v ? hold_rr    : '0;
  assign iss_read_ena  = hold_v ? hold_re    : '0;
  assign iss_writereg  = hold_v ? hold_wr    : '0;
  assign iss_write_ena = hold_v && hold_we;
  assign iss_flags     = hold_v ? hold_flags : '0;
  assign busy_vec      = busy_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: independent issue, RAW, FU stall,
// same-cycle set/clear, illegal FU, halt drain and reset during drain.
module tb_issue_scoreboard;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dec_valid;
  logic            dec_ready;
  logic [1:0][3:0] dec_readregs;
  logic [1:0]      dec_read_ena;
  logic [3:0]      dec_writereg;
  logic            dec_write_ena;
  logic [7:0]      dec_flags;
  logic [3:0]      dec_fuid;
  logic            dec_halt;
  logic [6:0]      fu_ready;
  logic            iss_valid;
  logic [3:0]      iss_fuid;
  logic [1:0][3:0] iss_readregs;
  logic [1:0]      iss_read_ena;
  logic [3:0]      iss_writereg;
  logic            iss_write_ena;
  logic [7:0]      iss_flags;
  logic            wb_valid;
  logic [3:0]      wb_reg;
  logic [15:0]     busy_vec;
  logic            halted;
  logic            illegal_fu;

  int unsigned checks = 0;
  int unsigned errors = 0;

  issue_scoreboard #(.NUM_REGS(16), .NUM_FU(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_readregs(dec_readregs), .dec_read_ena(dec_read_ena),
    .dec_writereg(dec_writereg), .dec_write_ena(dec_write_ena),
    .dec_flags(dec_flags), .dec_fuid(dec_fuid), .dec_halt(dec_halt),
    .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_fuid(iss_fuid),
    .iss_readregs(iss_readregs), .iss_read_ena(iss_read_ena),
    .iss_writereg(iss_writereg), .iss_write_ena(iss_write_ena),
    .iss_flags(iss_flags),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .busy_vec(busy_vec), .halted(halted), .illegal_fu(illegal_fu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [1:0] re, input logic [3:0] wr, input logic we,
                       input logic [7:0] fl, input logic [3:0] fu, input logic h);
    dec_valid     = v;
    dec_readregs  = {rb, ra};
    dec_read_ena  = re;
    dec_writereg  = wr;
    dec_write_ena = we;
    dec_flags     = fl;
    dec_fuid      = fu;
    dec_halt      = h;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    wb_valid = v;
    wb_reg   = r;
  endtask

  initial begin
    rst_n = 1'b0;
    fu_ready = 7'h7f;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0);
    #2;
    check("rst_busy", 32'(busy_vec), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_iss_valid", 32'(iss_valid), 32'h0);
    check("rst_illegal", 32'(illegal_fu), 32'h0);
    check("rst_iss_wr", 32'(iss_writereg), 32'h0);
    check("rst_dec_ready", 32'(dec_ready), 32'h1);
    #10 rst_n = 1'b1;
    tick();

    // Independent stream: r1 then r2 issue on consecutive cycles
    drive(1, 8, 9, 2'b11, 1, 1, 8'h11, 0, 0);
    settle();
    check("ind_ready0", 32'(dec_ready), 32'h1);
    tick();
    drive(1, 10, 11, 2'b11, 2, 1, 8'h22, 0, 0);
    settle();
    check("ind_iss1", 32'(iss_valid), 32'h1);
    check("ind_wr1", 32'(iss_writereg), 32'h1);
    check("ind_flags1", 32'(iss_flags), 32'h11);
    check("ind_ready1", 32'(dec_ready), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("ind_iss2", 32'(iss_valid), 32'h1);
    check("ind_wr2", 32'(iss_writereg), 32'h2);
    check("ind_busy_mid", 32'(busy_vec), 32'h0002);
    tick();
    check("ind_busy", 32'(busy_vec), 32'h0006);
    check("ind_idle", 32'(iss_valid), 32'h0);
    wb(1, 1); tick();
    wb(1, 2); tick();
    wb(0, 0);
    check("clr_busy0", 32'(busy_vec), 32'h0);

    // RAW on r3; writeback of r3 releases the consumer in the same cycle
    drive(1, 0, 0, 2'b00, 3, 1, 8'h00, 1, 0);
    tick();
    drive(1, 3, 0, 2'b01, 6, 1, 8'h00, 1, 0);
    settle();
    check("raw_prod_iss", 32'(iss_valid), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("raw_busy3", 32'(busy_vec), 32'h0008);
    check("raw_stall", 32'(iss_valid), 32'h0);
    check("raw_ready", 32'(dec_ready), 32'h0);
    tick();
    check("raw_stall2", 32'(iss_valid), 32'h0);
    wb(1, 3);
    settle();
    check("raw_wb_iss", 32'(iss_valid), 32'h1);
    check("raw_wb_ready", 32'(dec_ready), 32'h1);
    tick();
    wb(0, 0);
    settle();
    check("raw_busy6", 32'(busy_vec), 32'h0040);

    // FU stall on fuid 2
    fu_ready = 7'h7b;
    drive(1, 0, 0, 2'b00, 9, 1, 8'h5a, 2, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("fu_stall_iss", 32'(iss_valid), 32'h0);
      check("fu_stall_ready", 32'(dec_ready), 32'h0);
      tick();
    end
    fu_ready = 7'h7f;
    settle();
    check("fu_go_iss", 32'(iss_valid), 32'h1);
    check("fu_go_fuid", 32'(iss_fuid), 32'h2);
    tick();
    check("fu_busy", 32'(busy_vec), 32'h0240);

    // Same-cycle set and clear on r5
    drive(1, 0, 0, 2'b00, 5, 1, 8'h00, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 5, 1, 8'h00, 0, 0);
    settle();
    check("sc_first_iss", 32'(iss_valid), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("sc_waw_stall", 32'(iss_valid), 32'h0);
    wb(1, 5);
    settle();
    check("sc_iss", 32'(iss_valid), 32'h1);
    tick();
    wb(0, 0);
    check("sc_busy5", 32'(busy_vec), 32'h0260);
    wb(1, 5); tick();
    wb(1, 6); tick();
    wb(1, 9); tick();
    wb(1, 9); tick();
    wb(0, 0);
    check("clr_busy1", 32'(busy_vec), 32'h0);

    // Illegal fuid 9 is dropped with a one-cycle illegal_fu pulse
    drive(1, 0, 0, 2'b00, 12, 1, 8'h00, 9, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("ill_no_iss", 32'(iss_valid), 32'h0);
    check("ill_ready", 32'(dec_ready), 32'h1);
    check("ill_pre", 32'(illegal_fu), 32'h0);
    tick();
    check("ill_pulse", 32'(illegal_fu), 32'h1);
    check("ill_busy", 32'(busy_vec), 32'h0);
    check("ill_hold_empty", 32'(iss_writereg), 32'h0);
    tick();
    check("ill_pulse_end", 32'(illegal_fu), 32'h0);

    // Halt drain with r4 and r7 outstanding
    drive(1, 0, 0, 2'b00, 4, 1, 8'h00, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 7, 1, 8'h00, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("hd_busy", 32'(busy_vec), 32'h0090);
    check("hd_no_iss", 32'(iss_valid), 32'h0);
    check("hd_ready", 32'(dec_ready), 32'h0);
    tick();
    check("hd_drain_iss", 32'(iss_valid), 32'h0);
    check("hd_drain_halted", 32'(halted), 32'h0);
    wb(1, 4); tick();
    check("hd_after_r4", 32'(halted), 32'h0);
    check("hd_busy7", 32'(busy_vec), 32'h0080);
    wb(1, 7); tick();
    wb(0, 0);
    check("hd_halted", 32'(halted), 32'h1);
    check("hd_busy0", 32'(busy_vec), 32'h0);
    drive(1, 0, 0, 2'b00, 1, 1, 8'h00, 0, 0);
    settle();
    check("hd_ready_after", 32'(dec_ready), 32'h0);
    tick();
    check("hd_sticky", 32'(halted), 32'h1);
    check("hd_sticky_iss", 32'(iss_valid), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during DRAIN
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    drive(1, 0, 0, 2'b00, 4, 1, 8'h00, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 0, 0, 8'h00, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rd_drain_busy", 32'(busy_vec), 32'h0010);
    check("rd_drain_ready", 32'(dec_ready), 32'h0);
    rst_n = 1'b0;
    settle();
    check("rd_busy", 32'(busy_vec), 32'h0);
    check("rd_halted", 32'(halted), 32'h0);
    check("rd_ready", 32'(dec_ready), 32'h1);
    rst_n = 1'b1;
    wb(1, 4); tick();
    wb(0, 0);
    check("rd_stale_wb", 32'(busy_vec), 32'h0);
    drive(1, 0, 0, 2'b00, 3, 1, 8'h00, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rd_run_iss", 32'(iss_valid), 32'h1);
    tick();
    check("rd_run_busy", 32'(busy_vec), 32'h0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
